threewire_slave_ctrl: RTL and testbench
=======================================

# threewire_slave_ctrl

Device-side responder for the 3-wire serial bus driven by `threewire_master_ctrl`. It oversamples the bus clock, chip-select and data line in the system clock domain and decodes each frame into a command bit, an address and a data word. Write frames produce a one-cycle write strobe toward a local register file. Read frames fetch a word from that register file and shift it back on the shared data line. It sits at the far end of the bus, in the FPGA image that emulates or bridges a 3-wire peripheral.

## Interface
- `TWS_ADDRESS_BITS`, 10, address field width in bits.
- `TWS_DATA_BITS`, 32, data field width in bits.

- `in_clk`  input  1  system clock; all logic synchronous to it.
- `in_rst_n`  input  1  asynchronous, active-low reset.
- `in_tw_clock`  input  1  bus clock from master, asynchronous to `in_clk`.
- `in_tw_cs`  input  1  bus chip-select, active low.
- `io_tw_data`  inout  1  bidirectional bus data; high-Z unless driving read data.
- `out_addr`  output  `TWS_ADDRESS_BITS`  decoded address, valid from `out_rd_req` or `out_wr_strobe` until next frame start.
- `out_wr_data`  output  `TWS_DATA_BITS`  decoded write word, valid with `out_wr_strobe`.
- `out_wr_strobe`  output  1  one-cycle pulse: write frame complete.
- `out_rd_req`  output  1  one-cycle pulse: read address complete.
- `in_rd_data`  input  `TWS_DATA_BITS`  read word, sampled exactly 1 cycle after `out_rd_req`.
- `out_busy`  output  1  high while a frame is in progress.
- `out_frame_err`  output  1  one-cycle pulse: frame aborted by CS rising early.

## Operation
- **Frame format** (CS low for the whole frame, MSB first):
  - 1 command bit: 1 = write, 0 = read.
  - `TWS_ADDRESS_BITS` address bits.
  - `TWS_DATA_BITS` data bits.
- **Bus edges:** master drives on the bus-clock falling edge; the bit is sampled on the rising edge.
- **Synchronisers:** `in_tw_clock`, `in_tw_cs` and `io_tw_data` each pass through a 2-flop synchroniser. Edges are detected against a third registered copy.
- **Clock ratio:** `in_clk` ≥ 8× bus clock. Slower ratios are unsupported.
- **State machine:**
  - IDLE: wait for CS falling. Then clear the address and data shift registers, set `out_busy`, go to CMD.
  - CMD: on bus rising, latch the command bit, go to ADDR.
  - ADDR: shift one bit per bus rising edge. After the last address bit:
    - Write: go to WDATA.
    - Read: pulse `out_rd_req` and go to RDATA.
  - WDATA: shift one bit per bus rising edge. On the last bit, load `out_wr_data`, pulse `out_wr_strobe`, go to TAIL.
  - RDATA: the cycle after `out_rd_req`, load `in_rd_data` into the transmit shift register.
    - On each bus falling edge, enable the driver and present the next bit, starting with the MSB.
    - After all `TWS_DATA_BITS` are presented, release the driver on the following bus falling edge, then go to TAIL.
  - TAIL: ignore further bus clocks until CS rising, then go to IDLE.
- **Bit counter:** width `clog2(max(ADDRESS_BITS, DATA_BITS)+1)`, reloaded per field. No wrap-around beyond the field length.
- **CS rising** (synchronised) in any state other than IDLE:
  - Release the driver immediately and clear `out_busy`.
  - Return to IDLE.
  - If the state is not TAIL, pulse `out_frame_err`; no strobe or request is issued.
- **CS falling while not IDLE** (not possible without an intervening rise) is ignored.
- **Simultaneous events:** CS rising and bus rising detected in the same cycle → CS wins; the bit is discarded.

## Timing
- **Reset values:**
  - `out_addr`, `out_wr_data`: 0.
  - `out_wr_strobe`, `out_rd_req`, `out_busy`, `out_frame_err`: 0.
  - `io_tw_data`: high-Z.
  - State: IDLE.
- **Reset mid-frame:** immediate return to those values. The remainder of that frame is ignored, since the state waits in IDLE for the next CS falling.
- **Bus-edge detection latency:** 3 `in_clk` cycles from the pin.
- **Write strobe:** `out_wr_strobe` asserts 1 cycle after the rising-edge detect of the last data bit.
- **Read request:** `out_rd_req` asserts 1 cycle after the rising-edge detect of the last address bit.
- **Read turnaround:**
  - The driver enables on the first bus falling edge after the last address bit; the MSB is valid by the next rising edge.
  - `in_rd_data` must be stable in the cycle after `out_rd_req`.
  - The 8× ratio guarantees the load precedes the falling-edge detect.
- **Data-out stability:** data out changes only on falling-edge detect, so it is stable across the master's rising edge.
- **Busy window:** `out_busy` rises 1 cycle after CS-falling detect and falls 1 cycle after CS-rising detect.

## Test plan
- **Write frame, defaults:** cmd=1, addr=0x2A5, data=0xDEADBEEF at in_clk/16 → one `out_wr_strobe` pulse with `out_addr`=0x2A5, `out_wr_data`=0xDEADBEEF; `io_tw_data` never driven.
- **Read frame:** cmd=0, addr=0x013, responder returns `in_rd_data`=0xA5A5_0F0F → one `out_rd_req` with `out_addr`=0x013; master samples 32 bits equal to 0xA5A50F0F; line high-Z after the last bit.
- **Abort mid-address:** CS rises after 5 address bits → `out_frame_err` pulse, no strobe/request, `out_busy`=0, next full write frame decodes correctly.
- **Reset mid-read:** `in_rst_n` low during bit 10 of RDATA → line high-Z the same cycle, all outputs 0; following frame decodes correctly.
- **Back-to-back frames:** write 0x001/0x11111111, then read 0x001 with CS high for 2 bus periods between them → both frames complete, read returns the responder value.
- **Extra clocks:** 4 surplus bus clocks after a write frame before CS rises → exactly one `out_wr_strobe`, no `out_frame_err`.

Source files
------------

// File: rtl/threewire_slave_ctrl.sv
// threewire_slave_ctrl
// Device-side responder for a 3-wire serial bus (bus clock, active-low CS and
// one shared data line). The bus pins are oversampled in the in_clk domain.
// Each frame is decoded into a command bit, an address and a data word.
// A frame is sent MSB first: cmd (1 = write, 0 = read), address, data.
// Write frames end in a one-cycle write strobe. Read frames issue a one-cycle
// read request, then shift the returned word back onto the data line.
//
// Ports
//   in_clk, in_rst_n      system clock, asynchronous active-low reset
//   in_tw_clock, in_tw_cs bus clock and chip-select (asynchronous to in_clk)
//   io_tw_data            shared data line, high-Z unless returning read data
//   out_addr              decoded address (valid from request/strobe until
//                         the next frame start)
//   out_wr_data           decoded write word, valid with out_wr_strobe
//   out_wr_strobe         one-cycle pulse: write frame complete
//   out_rd_req            one-cycle pulse: read address complete
//   in_rd_data            read word, sampled the cycle after out_rd_req
//   out_busy              high while a frame is in progress
//   out_frame_err         one-cycle pulse: CS rose before the frame completed
module threewire_slave_ctrl #(
   parameter int TWS_ADDRESS_BITS = 10,
   parameter int TWS_DATA_BITS    = 32
) (
   input  logic                        in_clk,
   input  logic                        in_rst_n,
   input  logic                        in_tw_clock,
   input  logic                        in_tw_cs,
   inout  wire                         io_tw_data,
   output logic [TWS_ADDRESS_BITS-1:0] out_addr,
   output logic [TWS_DATA_BITS-1:0]    out_wr_data,
   output logic                        out_wr_strobe,
   output logic                        out_rd_req,
   input  logic [TWS_DATA_BITS-1:0]    in_rd_data,
   output logic                        out_busy,
   output logic                        out_frame_err
);

   localparam int MAX_BITS = (TWS_ADDRESS_BITS > TWS_DATA_BITS) ? TWS_ADDRESS_BITS : TWS_DATA_BITS;
   localparam int CNT_W    = $clog2(MAX_BITS + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RDATA, S_TAIL
   } state_t;

   // [0],[1] form the synchroniser; [2] is the delayed copy used for edges.
   // All reset to 0 so that a reset released while CS is low cannot look
   // like a CS falling edge; a spurious rise is harmless in IDLE.
   logic [2:0] twclk_q;
   logic [2:0] twcs_q;
   logic [1:0] twdat_q;

   state_t                          state_q;
   logic                            cmd_q;
   logic [CNT_W-1:0]                cnt_q;
   logic [TWS_ADDRESS_BITS-1:0]     addr_sh_q;
   // The last data bit goes straight into out_wr_data, so one bit less is kept.
   logic [TWS_DATA_BITS-2:0]        data_sh_q;
   logic [TWS_DATA_BITS-1:0]        tx_sh_q;
   logic [TWS_DATA_BITS-1:0]        wr_data_q;
   logic                            load_q;
   logic                            drv_en_q;
   logic                            drv_bit_q;
   logic                            wr_strobe_q;
   logic                            rd_req_q;
   logic                            busy_q;
   logic                            frame_err_q;

   logic bus_rise, bus_fall, cs_rise, cs_fall, bus_bit;

   assign bus_rise = twclk_q[1] & ~twclk_q[2];
   assign bus_fall = ~twclk_q[1] & twclk_q[2];
   assign cs_rise  = twcs_q[1] & ~twcs_q[2];
   assign cs_fall  = ~twcs_q[1] & twcs_q[2];
   assign bus_bit  = twdat_q[1];

   assign io_tw_data    = drv_en_q ? drv_bit_q : 1'bz;
   assign out_addr      = addr_sh_q;
   assign out_wr_data   = wr_data_q;
   assign out_wr_strobe = wr_strobe_q;
   assign out_rd_req    = rd_req_q;
   assign out_busy      = busy_q;
   assign out_frame_err = frame_err_q;

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         twclk_q     <= '0;
         twcs_q      <= '0;
         twdat_q     <= '0;
         state_q     <= S_IDLE;
         cmd_q       <= 1'b0;
         cnt_q       <= '0;
         addr_sh_q   <= '0;
         data_sh_q   <= '0;
         tx_sh_q     <= '0;
         wr_data_q   <= '0;
         load_q      <= 1'b0;
         drv_en_q    <= 1'b0;
         drv_bit_q   <= 1'b0;
         wr_strobe_q <= 1'b0;
         rd_req_q    <= 1'b0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         twclk_q     <= {twclk_q[1:0], in_tw_clock};
         twcs_q      <= {twcs_q[1:0], in_tw_cs};
         twdat_q     <= {twdat_q[0], io_tw_data};
         wr_strobe_q <= 1'b0;
         rd_req_q    <= 1'b0;
         frame_err_q <= 1'b0;
         // in_rd_data is taken one cycle after the request pulse.
         load_q      <= rd_req_q;

         // CS rising outranks any bus edge seen in the same cycle.
         if (state_q != S_IDLE && cs_rise) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            drv_en_q    <= 1'b0;
            frame_err_q <= (state_q != S_TAIL);
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (cs_fall) begin
                     addr_sh_q <= '0;
                     data_sh_q <= '0;
                     busy_q    <= 1'b1;
                     state_q   <= S_CMD;
                  end
               end
               S_CMD: begin
                  if (bus_rise) begin
                     cmd_q   <= bus_bit;
                     cnt_q   <= CNT_W'(TWS_ADDRESS_BITS);
                     state_q <= S_ADDR;
                  end
               end
               S_ADDR: begin
                  if (bus_rise) begin
                     addr_sh_q <= {addr_sh_q[TWS_ADDRESS_BITS-2:0], bus_bit};
                     cnt_q     <= cnt_q - CNT_W'(1);
                     if (cnt_q == CNT_W'(1)) begin
                        cnt_q <= CNT_W'(TWS_DATA_BITS);
                        if (cmd_q) begin
                           state_q <= S_WDATA;
                        end else begin
                           rd_req_q <= 1'b1;
                           state_q  <= S_RDATA;
                        end
                     end
                  end
               end
               S_WDATA: begin
                  if (bus_rise) begin
                     data_sh_q <= {data_sh_q[TWS_DATA_BITS-3:0], bus_bit};
                     cnt_q     <= cnt_q - CNT_W'(1);
                     if (cnt_q == CNT_W'(1)) begin
                        wr_data_q   <= {data_sh_q, bus_bit};
                        wr_strobe_q <= 1'b1;
                        state_q     <= S_TAIL;
                     end
                  end
               end
               S_RDATA: begin
                  // The clock ratio guarantees the load lands before the
                  // first falling-edge detect, so the two never coincide.
                  if (load_q) begin
                     tx_sh_q <= in_rd_data;
                  end else if (bus_fall) begin
                     if (cnt_q != '0) begin
                        drv_en_q  <= 1'b1;
                        drv_bit_q <= tx_sh_q[TWS_DATA_BITS-1];
                        tx_sh_q   <= {tx_sh_q[TWS_DATA_BITS-2:0], 1'b0};
                        cnt_q     <= cnt_q - CNT_W'(1);
                     end else begin
                        // One falling edge past the last bit: hand the line back.
                        drv_en_q <= 1'b0;
                        state_q  <= S_TAIL;
                     end
                  end
               end
               S_TAIL: begin
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_threewire_slave_ctrl.sv
// Directed bench for threewire_slave_ctrl: a behavioural bus master drives
// frames at in_clk/16 and a negedge monitor counts and captures the pulses.
module tb_threewire_slave_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tw_clk;
   logic        tw_cs;
   logic        m_en;
   logic        m_bit;
   wire         tw_data;
   logic [9:0]  addr;
   logic [31:0] wr_data;
   logic        wr_strobe;
   logic        rd_req;
   logic [31:0] rd_data;
   logic        busy;
   logic        ferr;

   int checks = 0;
   int errors = 0;

   int          n_wr = 0, n_rd = 0, n_err = 0;
   logic [9:0]  mon_wr_addr = '0, mon_rd_addr = '0;
   logic [31:0] mon_wd = '0;

   always #5 clk = ~clk;

   assign tw_data = m_en ? m_bit : 1'bz;

   threewire_slave_ctrl #(.TWS_ADDRESS_BITS(10), .TWS_DATA_BITS(32)) dut (
      .in_clk        (clk),
      .in_rst_n      (rst_n),
      .in_tw_clock   (tw_clk),
      .in_tw_cs      (tw_cs),
      .io_tw_data    (tw_data),
      .out_addr      (addr),
      .out_wr_data   (wr_data),
      .out_wr_strobe (wr_strobe),
      .out_rd_req    (rd_req),
      .in_rd_data    (rd_data),
      .out_busy      (busy),
      .out_frame_err (ferr)
   );

   always @(negedge clk) begin
      if (wr_strobe) begin
         n_wr++;
         mon_wr_addr = addr;
         mon_wd      = wr_data;
      end
      if (rd_req) begin
         n_rd++;
         mon_rd_addr = addr;
      end
      if (ferr) n_err++;
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cs_low();
      tw_cs = 1'b0;
      wait_cyc(8);
   endtask

   task automatic cs_high(input int gap);
      wait_cyc(4);
      tw_cs = 1'b1;
      m_en  = 1'b0;
      wait_cyc(gap);
   endtask

   task automatic send_bit(input logic b);
      tw_clk = 1'b0;
      m_en   = 1'b1;
      m_bit  = b;
      wait_cyc(8);
      tw_clk = 1'b1;
      wait_cyc(8);
   endtask

   task automatic write_frame(input logic [9:0] a, input logic [31:0] d, input int extra, input int gap);
      cs_low();
      send_bit(1'b1);
      for (int i = 9; i >= 0; i--) send_bit(a[i]);
      for (int i = 31; i >= 0; i--) send_bit(d[i]);
      for (int i = 0; i < extra; i++) send_bit(1'b0);
      cs_high(gap);
   endtask

   // rst_bit > 0 pulls reset while the slave is driving that read bit.
   task automatic read_frame(input logic [9:0] a, input int rst_bit,
                             output logic [31:0] got, output logic line_hi);
      got     = '0;
      line_hi = 1'b0;
      cs_low();
      send_bit(1'b0);
      for (int i = 9; i >= 0; i--) send_bit(a[i]);
      for (int i = 1; i <= 32; i++) begin
         tw_clk = 1'b0;
         m_en   = 1'b0;
         if (i == rst_bit) begin
            wait_cyc(6);
            check_val("rstmid_line_driven", {63'd0, tw_data === 1'b1}, 64'd1);
            rst_n = 1'b0;
            #1;
            check_val("rstmid_line_released", {63'd0, tw_data === 1'b1}, 64'd0);
            check_val("rstmid_addr", {54'd0, addr}, 64'd0);
            check_val("rstmid_wr_data", {32'd0, wr_data}, 64'd0);
            check_val("rstmid_busy", {63'd0, busy}, 64'd0);
            check_val("rstmid_pulses", {61'd0, wr_strobe, rd_req, ferr}, 64'd0);
            wait_cyc(2);
            tw_clk = 1'b1;
            wait_cyc(8);
            tw_cs = 1'b1;
            wait_cyc(4);
            rst_n = 1'b1;
            wait_cyc(16);
            return;
         end
         wait_cyc(8);
         tw_clk = 1'b1;
         got    = {got[30:0], tw_data === 1'b1};
         wait_cyc(8);
      end
      tw_clk = 1'b0;
      wait_cyc(8);
      line_hi = (tw_data === 1'b1);
      tw_clk  = 1'b1;
      wait_cyc(8);
      cs_high(16);
   endtask

   task automatic write_and_check(input string tag, input logic [9:0] a, input logic [31:0] d,
                                  input int extra, input int gap);
      int wr0, rd0, er0;
      wr0 = n_wr; rd0 = n_rd; er0 = n_err;
      write_frame(a, d, extra, gap);
      check_val({tag, "_wr_count"}, 64'(n_wr - wr0), 64'd1);
      check_val({tag, "_rd_count"}, 64'(n_rd - rd0), 64'd0);
      check_val({tag, "_err_count"}, 64'(n_err - er0), 64'd0);
      check_val({tag, "_addr"}, {54'd0, mon_wr_addr}, {54'd0, a});
      check_val({tag, "_data"}, {32'd0, mon_wd}, {32'd0, d});
      check_val({tag, "_busy"}, {63'd0, busy}, 64'd0);
      $display("write %s addr=0x%03h data=0x%08h strobes=%0d", tag, a, d, n_wr - wr0);
   endtask

   task automatic read_and_check(input string tag, input logic [9:0] a, input logic [31:0] resp);
      int          rd0, er0;
      logic [31:0] got;
      logic        line_hi;
      rd0 = n_rd; er0 = n_err;
      rd_data = resp;
      read_frame(a, 0, got, line_hi);
      check_val({tag, "_rd_count"}, 64'(n_rd - rd0), 64'd1);
      check_val({tag, "_err_count"}, 64'(n_err - er0), 64'd0);
      check_val({tag, "_addr"}, {54'd0, mon_rd_addr}, {54'd0, a});
      check_val({tag, "_rdata"}, {32'd0, got}, {32'd0, resp});
      check_val({tag, "_released"}, {63'd0, line_hi}, 64'd0);
      $display("read %s addr=0x%03h got=0x%08h", tag, a, got);
   endtask

   initial begin
      int          wr0, rd0, er0;
      logic [31:0] got;
      logic        line_hi;

      rst_n = 1'b0; tw_clk = 1'b1; tw_cs = 1'b1; m_en = 1'b0; m_bit = 1'b0; rd_data = '0;
      wait_cyc(4);
      check_val("reset_addr", {54'd0, addr}, 64'd0);
      check_val("reset_wr_data", {32'd0, wr_data}, 64'd0);
      check_val("reset_busy", {63'd0, busy}, 64'd0);
      check_val("reset_pulses", {61'd0, wr_strobe, rd_req, ferr}, 64'd0);
      rst_n = 1'b1;
      wait_cyc(8);
      $display("reset released");

      write_and_check("wr_default", 10'h2A5, 32'hDEADBEEF, 0, 16);
      read_and_check("rd_basic", 10'h013, 32'hA5A50F0F);

      // Abort after five address bits.
      wr0 = n_wr; rd0 = n_rd; er0 = n_err;
      cs_low();
      send_bit(1'b1);
      for (int i = 0; i < 5; i++) send_bit(i[0]);
      check_val("abort_busy_mid", {63'd0, busy}, 64'd1);
      cs_high(16);
      check_val("abort_err_count", 64'(n_err - er0), 64'd1);
      check_val("abort_strobes", 64'((n_wr - wr0) + (n_rd - rd0)), 64'd0);
      check_val("abort_busy_after", {63'd0, busy}, 64'd0);
      $display("abort after 5 address bits err_pulses=%0d", n_err - er0);
      write_and_check("wr_after_abort", 10'h155, 32'h12345678, 0, 16);

      // Reset while the slave drives bit 10 of a read.
      rd0 = n_rd; er0 = n_err;
      rd_data = 32'hFFFFFFFF;
      read_frame(10'h0AA, 10, got, line_hi);
      check_val("rstmid_rd_count", 64'(n_rd - rd0), 64'd1);
      check_val("rstmid_err_count", 64'(n_err - er0), 64'd0);
      $display("read with reset at bit 10 addr=0x0AA");
      write_and_check("wr_after_reset", 10'h0C3, 32'hCAFEF00D, 0, 16);

      // Back-to-back with two bus periods of CS high between frames.
      write_and_check("b2b_wr", 10'h001, 32'h11111111, 0, 32);
      read_and_check("b2b_rd", 10'h001, 32'h5A5AC3C3);

      write_and_check("extra_clocks", 10'h3FF, 32'h80000001, 4, 16);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
